defuzz_centroide: RTL and testbench
===================================

Name: defuzz_centroide

Overview:
- Defuzzification stage, at the opposite end of the fuzzy chain from the trapezoid membership dividers.
- Accepts a stream of (degree, singleton centre) pairs, one per fired output rule. Degrees are scaled 0..100, the same scale the membership stage produces.
- Accumulates the sums Σ(Grau·Centro) and ΣGrau, then runs a multicycle restoring divider.
- Emits the crisp output Saida = Σ(Grau·Centro)/ΣGrau with a valid/ready handshake.

Parameters:
- N_REGRAS, 9, maximum beats per frame; the Nth accepted beat ends the frame even without in_last.
- W, 32, width of Grau, Centro and Saida.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  last beat of the frame.
- Grau  in  W  rule strength, unsigned, nominal 0..100.
- Centro  in  W  singleton centre of the output set, unsigned.
- out_valid  out  1  Saida and Div_zero are valid.
- out_ready  in  1  downstream accepts the result.
- Saida  out  W  crisp output, unsigned.
- Div_zero  out  1  ΣGrau was 0 for this frame.

Behaviour:
- Reset, asynchronous active-low, also mid-operation:
  - state=OCIOSO.
  - Accumulators and beat counter cleared.
  - out_valid=0, Saida=0, Div_zero=0, in_ready=0 while rst_n low.
  - Any partial frame is discarded.
- States:
  - OCIOSO: in_ready=1. First accepted beat (in_valid & in_ready) accumulates and moves to ACUMULA. If that beat is also last, go to DIVIDE (or SAIDA, see zero case).
  - ACUMULA: in_ready=1. Every accepted beat adds to the accumulators. Beat ends the frame if in_last=1 or beat count reaches N_REGRAS. End of frame → DIVIDE, or SAIDA if ΣGrau=0.
  - DIVIDE: in_ready=0. Restoring divide, one quotient bit per cycle, 2W cycles. Then go to SAIDA.
  - SAIDA: out_valid=1; Saida and Div_zero held stable. Leave on out_valid & out_ready → OCIOSO, out_valid=0 next cycle.
- Arithmetic:
  - Grau clamped to 100 if greater before use.
  - Numerator accumulator is 2W bits; product Grau·Centro is zero-extended.
  - Denominator accumulator is W bits.
  - Quotient is never larger than the largest Centro, so it always fits in W bits.
  - Result is truncated, except when the optional feature is enabled.
- ΣGrau=0 at end of frame: skip DIVIDE, Saida=0, Div_zero=1, out_valid the next cycle.
- Latency, nonzero case: out_valid rises 2W+1 cycles after the clock edge that accepted the last beat (65 for W=32).
- in_valid while in_ready=0 is ignored; the upstream holds the beat.
- out_ready held low: block stays in SAIDA indefinitely and accepts no new frame.

Optional Feature:
- Macro DEFUZZ_ARRED_EN.
- Defined: ΣGrau>>1 is added to the numerator before division, giving round-half-up.
- Undefined: truncating quotient, matching the existing integer dividers.
- Latency is identical in both builds.

Decomposition:
- Package defuzz_pkg holds:
  - the state enum (OCIOSO, ACUMULA, DIVIDE, SAIDA);
  - the constant GRAU_MAX=100;
  - the width constants W and 2W.
- Natural sub-module: div_restauradora. Iterative unsigned restoring divider, 2W-bit dividend by W-bit divisor, with start/busy/done. Reusable by the membership stage later.

Test Plan:
- Single beat Grau=100, Centro=50, in_last=1 → Saida=50, Div_zero=0, out_valid exactly 65 cycles after acceptance.
- Beats (30,10), (70,20) → numerator 1700, denominator 100, Saida=17.
- Beats (1,0), (2,1):
  - without DEFUZZ_ARRED_EN → Saida=0;
  - with DEFUZZ_ARRED_EN → Saida=1.
- All beats Grau=0 → Saida=0, Div_zero=1, out_valid one cycle after the last beat.
- Grau=250 with Centro=40, plus (100,80) → clamped, Saida=60.
- Backpressure and abort cases:
  - out_ready low 20 cycles → Saida stable, in_ready=0.
  - 10 beats sent without in_last (N_REGRAS=9) → frame closes at beat 9 and the 10th is not accepted until SAIDA completes.
  - rst_n pulsed mid-DIVIDE → out_valid=0, and the next frame's result is unaffected.

Source files
------------

// File: rtl/defuzz_pkg.sv
// Shared types and constants for the centroid defuzzification stage.
package defuzz_pkg;

   typedef enum logic [1:0] {
      OCIOSO,
      ACUMULA,
      DIVIDE,
      SAIDA
   } estado_t;

   localparam int GRAU_MAX  = 100;
   localparam int W_PADRAO  = 32;
   localparam int W2_PADRAO = 2 * W_PADRAO;

endpackage

// File: rtl/defuzz_centroide_div_restauradora.sv
// Iterative unsigned restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per cycle after the start cycle, done pulses once when finished.
module div_restauradora
   import defuzz_pkg::*;
#(
   parameter int W = W_PADRAO
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2*W-1:0]   dividendo,
   input  logic [W-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   quociente,
   output logic [W-1:0]     resto
);

   localparam int W2 = 2 * W;
   localparam int CW = $clog2(W2 + 1);

   logic [CW-1:0] cnt;
   logic [W-1:0]  div_r;
   logic [W-1:0]  rem;
   logic [W2-1:0] quo;
   logic [W:0]    parcial;
   logic [W-1:0]  diff;
   logic          ge;

   // The remainder stays below the divisor, so the low W bits of the difference are exact.
   always_comb begin
      parcial = {rem, quo[W2-1]};
      ge      = (parcial >= {1'b0, div_r});
      diff    = parcial[W-1:0] - div_r;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= CW'(W2);
         end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start && !busy) begin
         quo   <= dividendo;
         rem   <= '0;
         div_r <= divisor;
      end else if (busy) begin
         quo <= {quo[W2-2:0], ge};
         rem <= ge ? diff : parcial[W-1:0];
      end
   end

   assign quociente = quo;
   assign resto     = rem;

endmodule

// File: rtl/defuzz_centroide.sv
// Centroid defuzzifier: Saida = sum(Grau*Centro)/sum(Grau) over a frame of rule beats.
// Define DEFUZZ_ARRED_EN for round-half-up instead of a truncating quotient.
module defuzz_centroide
   import defuzz_pkg::*;
#(
   parameter int N_REGRAS = 9,
   parameter int W        = W_PADRAO
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_last,
   input  logic [W-1:0] Grau,
   input  logic [W-1:0] Centro,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] Saida,
   output logic         Div_zero
);

   localparam int W2 = 2 * W;
   localparam int CB = $clog2(N_REGRAS + 1);
`ifdef DEFUZZ_ARRED_EN
   localparam bit ARRED = 1'b1;
`else
   localparam bit ARRED = 1'b0;
`endif

   function automatic logic [W-1:0] satura_grau(input logic [W-1:0] g);
      return (g > W'(GRAU_MAX)) ? W'(GRAU_MAX) : g;
   endfunction

   function automatic logic [W2-1:0] arredonda(input logic [W2-1:0] num,
                                               input logic [W-1:0]  den);
      return ARRED ? (num + W2'(den >> 1)) : num;
   endfunction

   estado_t       estado, prox;
   logic [W2-1:0] acc_num, base_num, num_prox;
   logic [W-1:0]  acc_den, base_den, den_prox, grau_c;
   logic [CB-1:0] n_batidas, base_bat, batidas_prox;
   logic          aceita, fim_quadro, den_nulo, div_start;
   logic          div_busy, div_done;
   logic [W2-1:0] quociente;
   logic [W-1:0]  resto;
   logic          unused_div;

   assign in_ready  = rst_n && ((estado == OCIOSO) || (estado == ACUMULA));
   assign out_valid = (estado == SAIDA);
   assign aceita    = in_valid && in_ready;

   // A new frame starts from zero, so the first beat overwrites rather than adds.
   always_comb begin
      base_num     = (estado == OCIOSO) ? '0 : acc_num;
      base_den     = (estado == OCIOSO) ? '0 : acc_den;
      base_bat     = (estado == OCIOSO) ? '0 : n_batidas;
      grau_c       = satura_grau(Grau);
      num_prox     = base_num + (W2'(grau_c) * W2'(Centro));
      den_prox     = base_den + grau_c;
      batidas_prox = base_bat + CB'(1);
      fim_quadro   = aceita && (in_last || (batidas_prox == CB'(N_REGRAS)));
      den_nulo     = (den_prox == '0);
      div_start    = fim_quadro && !den_nulo;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO, ACUMULA: begin
            if (fim_quadro)
               prox = den_nulo ? SAIDA : DIVIDE;
            else if (aceita)
               prox = ACUMULA;
         end
         DIVIDE:  if (div_done)  prox = SAIDA;
         SAIDA:   if (out_ready) prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= OCIOSO;
         acc_num   <= '0;
         acc_den   <= '0;
         n_batidas <= '0;
         Saida     <= '0;
         Div_zero  <= 1'b0;
      end else begin
         estado <= prox;
         if (aceita) begin
            acc_num   <= num_prox;
            acc_den   <= den_prox;
            n_batidas <= batidas_prox;
         end
         if (fim_quadro && den_nulo) begin
            Saida    <= '0;
            Div_zero <= 1'b1;
         end else if ((estado == DIVIDE) && div_done) begin
            Saida    <= quociente[W-1:0];
            Div_zero <= 1'b0;
         end
      end
   end

   // The divider is fed the post-beat sums so it starts on the same edge that closes the frame.
   div_restauradora #(.W(W)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividendo (arredonda(num_prox, den_prox)),
      .divisor   (den_prox),
      .busy      (div_busy),
      .done      (div_done),
      .quociente (quociente),
      .resto     (resto)
   );

   assign unused_div = ^{quociente[W2-1:W], resto, div_busy};

endmodule

// File: tb/tb_defuzz_centroide.sv
// Self-checking bench for defuzz_centroide: behavioural frame model plus literal pins.
module tb_defuzz_centroide;

   localparam int W        = 32;
   localparam int N_REGRAS = 9;
   localparam int LAT      = 2 * W + 1;
`ifdef DEFUZZ_ARRED_EN
   localparam bit ARRED = 1'b1;
`else
   localparam bit ARRED = 1'b0;
`endif

   typedef struct {
      longint unsigned saida;
      bit              dz;
      int              bordas;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] Grau = '0;
   logic [W-1:0] Centro = '0;
   logic         in_ready, out_valid, Div_zero;
   logic [W-1:0] Saida;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   defuzz_centroide #(.N_REGRAS(N_REGRAS), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .Grau      (Grau),
      .Centro    (Centro),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Saida     (Saida),
      .Div_zero  (Div_zero)
   );

   task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, exp, cyc);
      end
   endtask

   // Frame-level model: a result becomes visible a fixed number of edges after the closing beat.
   res_t            modelo_q[$];
   res_t            obs_q[$];
   res_t            m_atual;
   bit              ocupado = 1'b0;
   int              t_pronto = 0;
   int              t_fim = 0;
   longint unsigned m_num = 0;
   longint unsigned m_den = 0;
   int              m_nb = 0;

   always @(posedge clk) begin
      bit              ov_antes;
      longint unsigned g;
      ov_antes = ocupado && (cyc >= t_pronto);
      cyc++;
      if (!rst_n) begin
         ocupado = 1'b0;
         m_num = 0;
         m_den = 0;
         m_nb = 0;
         modelo_q.delete();
         obs_q.delete();
      end else if (ov_antes) begin
         if (out_ready) ocupado = 1'b0;
      end else if (!ocupado && in_valid) begin
         g = (Grau > 100) ? 100 : Grau;
         m_num += g * Centro;
         m_den += g;
         m_nb++;
         if (in_last || m_nb == N_REGRAS) begin
            ocupado = 1'b1;
            t_fim = cyc;
            if (m_den == 0) begin
               m_atual.saida = 0;
               m_atual.dz = 1'b1;
               t_pronto = cyc;
            end else begin
               m_atual.saida = (m_num + (ARRED ? m_den / 2 : 0)) / m_den;
               m_atual.dz = 1'b0;
               t_pronto = cyc + LAT;
            end
            m_atual.bordas = t_pronto - cyc;
            modelo_q.push_back(m_atual);
            m_num = 0;
            m_den = 0;
            m_nb = 0;
         end
      end
   end

   bit prev_ov = 1'b0;

   always @(negedge clk) begin
      bit   exp_ov;
      res_t r;
      if (!rst_n) begin
         chk("rst_in_ready", 64'(in_ready), 64'(0));
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_saida", 64'(Saida), 64'(0));
         chk("rst_div_zero", 64'(Div_zero), 64'(0));
         prev_ov = 1'b0;
      end else begin
         exp_ov = ocupado && (cyc >= t_pronto);
         chk("in_ready", 64'(in_ready), 64'(!ocupado));
         chk("out_valid", 64'(out_valid), 64'(exp_ov));
         if (exp_ov) begin
            chk("saida", 64'(Saida), m_atual.saida);
            chk("div_zero", 64'(Div_zero), 64'(m_atual.dz));
         end
         if (out_valid && !prev_ov) begin
            r.saida = Saida;
            r.dz = Div_zero;
            r.bordas = cyc - t_fim;
            obs_q.push_back(r);
         end
         prev_ov = out_valid;
      end
   end

   bit rnd_ready = 1'b0;

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [W-1:0] g, input logic [W-1:0] c, input bit last);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      Grau = g;
      Centro = c;
      in_last = last;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_beat: beat never accepted, got in_ready=0, expected 1");
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
         if (!ocupado) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: result never consumed, got busy, expected idle");
      end
   endtask

   // Latency is counted in clock edges from the edge that accepted the closing beat.
   task automatic check_frame(input longint unsigned s, input bit dz, input int bordas);
      res_t r;
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL frame_seen: got 0 results, expected 1");
      end else begin
         r = obs_q.pop_front();
         chk("frame_saida", 64'(r.saida), 64'(s));
         chk("frame_div_zero", 64'(r.dz), 64'(dz));
         chk("frame_latency", 64'(r.bordas), 64'(bordas));
      end
      checks++;
      if (modelo_q.size() == 0) begin
         errors++;
         $display("FAIL model_seen: got 0 results, expected 1");
      end else begin
         r = modelo_q.pop_front();
         chk("model_saida", 64'(r.saida), 64'(s));
         chk("model_div_zero", 64'(r.dz), 64'(dz));
      end
   endtask

   initial begin
      bit ok;
      int nb;
      logic [W-1:0] g, c;

      tick(3);
      rst_n = 1'b1;
      tick(2);

      send_beat(100, 50, 1'b1);
      wait_idle();
      check_frame(50, 1'b0, LAT);

      send_beat(30, 10, 1'b0);
      send_beat(70, 20, 1'b1);
      wait_idle();
      check_frame(17, 1'b0, LAT);

      send_beat(1, 0, 1'b0);
      send_beat(2, 1, 1'b1);
      wait_idle();
      check_frame(ARRED ? 1 : 0, 1'b0, LAT);

      send_beat(0, 5, 1'b0);
      send_beat(0, 7, 1'b1);
      wait_idle();
      check_frame(0, 1'b1, 0);

      send_beat(250, 40, 1'b0);
      send_beat(100, 80, 1'b1);
      wait_idle();
      check_frame(60, 1'b0, LAT);

      out_ready = 1'b0;
      send_beat(100, 50, 1'b1);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      chk("bp_reached_saida", 64'(ok), 64'(1));
      Grau = 100;
      Centro = 7;
      in_last = 1'b1;
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("bp_saida", 64'(Saida), 64'(50));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_out_valid", 64'(out_valid), 64'(1));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_beat(100, 7, 1'b1);
      wait_idle();
      check_frame(50, 1'b0, LAT);
      check_frame(7, 1'b0, LAT);

      for (int i = 1; i <= 9; i++) send_beat(10, W'(10 * i), 1'b0);
      send_beat(10, 1000, 1'b0);
      send_beat(10, 20, 1'b1);
      wait_idle();
      check_frame(50, 1'b0, LAT);
      check_frame(510, 1'b0, LAT);

      send_beat(100, 50, 1'b1);
      tick(20);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("abort_out_valid", 64'(out_valid), 64'(0));
      chk("abort_in_ready", 64'(in_ready), 64'(1));
      send_beat(30, 10, 1'b0);
      send_beat(70, 20, 1'b1);
      wait_idle();
      check_frame(17, 1'b0, LAT);

      rnd_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         nb = $urandom_range(1, 10);
         for (int i = 0; i < nb; i++) begin
            case ($urandom_range(0, 5))
               0:       g = '0;
               1:       g = $urandom;
               default: g = $urandom_range(0, 120);
            endcase
            c = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
            send_beat(g, c, (i == nb - 1) && (nb <= N_REGRAS) && ($urandom_range(0, 4) != 0));
            tick($urandom_range(0, 2));
         end
      end
      send_beat(5, 5, 1'b1);
      rnd_ready = 1'b0;
      tick(2);
      out_ready = 1'b1;
      wait_idle();
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
